// File: rtl/regfile_fwd_pkg.sv
// Shared widths and constants for the forwarding register file (RegBus/RegAddrBus equivalents).
package regfile_fwd_pkg;

  localparam int REG_BUS_W      = 32;
  localparam int REG_ADDR_BUS_W = 5;

  localparam logic [REG_BUS_W-1:0]      ZERO_WORD    = '0;
  localparam logic [REG_ADDR_BUS_W-1:0] NOP_REG_ADDR = '0;

  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic READ_ENABLE  = 1'b1;

  // Which path a read port resolved to.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_FWD,
    SRC_WB,
    SRC_ARRAY
  } rd_src_e;

endpackage

// File: rtl/regfile_fwd_port.sv
// Per-read-port resolve unit: picks forwarded, write-back or stored data and flags load-use hazards.
module regfile_fwd_port
  import regfile_fwd_pkg::*;
#(
  parameter int DATA_W   = REG_BUS_W,
  parameter int ADDR_W   = REG_ADDR_BUS_W,
  parameter int FWD_SRCS = 2
) (
  input  logic                       rst,
  input  logic                       re,
  input  logic [ADDR_W-1:0]          raddr,
  input  logic [FWD_SRCS-1:0]        fwd_we,
  input  logic [FWD_SRCS*ADDR_W-1:0] fwd_addr,
  input  logic [FWD_SRCS*DATA_W-1:0] fwd_data,
  input  logic [FWD_SRCS-1:0]        fwd_valid,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [DATA_W-1:0]          arr_data,
  output logic [DATA_W-1:0]          rdata,
  output logic                       hazard
);

  logic              hit;
  logic              hit_valid;
  logic [DATA_W-1:0] hit_data;
  rd_src_e           src;

  // Scan oldest to youngest so the youngest matching source is the one left standing.
  always_comb begin
    hit       = 1'b0;
    hit_valid = 1'b0;
    hit_data  = '0;
    for (int s = FWD_SRCS - 1; s >= 0; s--) begin
      if (fwd_we[s] && (fwd_addr[s*ADDR_W +: ADDR_W] == raddr)) begin
        hit       = 1'b1;
        hit_valid = fwd_valid[s];
        hit_data  = fwd_data[s*DATA_W +: DATA_W];
      end
    end
  end

  // raddr==0 is filtered first, so a source aimed at r0 can never match.
  always_comb begin
    src = SRC_NONE;
    if (rst || (re != READ_ENABLE) || (raddr == ADDR_W'(NOP_REG_ADDR))) begin
      src = SRC_NONE;
    end else if (hit) begin
      src = SRC_FWD;
    end else if (we && (waddr == raddr)) begin
      src = SRC_WB;
    end else begin
      src = SRC_ARRAY;
    end
  end

  always_comb begin
    rdata  = DATA_W'(ZERO_WORD);
    hazard = 1'b0;
    case (src)
      SRC_FWD: begin
        if (hit_valid) begin
          rdata = hit_data;
        end else begin
          hazard = 1'b1;
        end
      end
      SRC_WB:    rdata = wdata;
      SRC_ARRAY: rdata = arr_data;
      default:   rdata = DATA_W'(ZERO_WORD);
    endcase
  end

endmodule

// File: rtl/regfile_fwd.sv
// Register file with EX/MEM forwarding and load-use stall detection.
// Define REGFILE_STALL_CNT_EN to add the saturating stall_cnt output.
module regfile_fwd
  import regfile_fwd_pkg::*;
#(
  parameter int DATA_W   = REG_BUS_W,
  parameter int ADDR_W   = REG_ADDR_BUS_W,
  parameter int RD_PORTS = 2,
  parameter int FWD_SRCS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [RD_PORTS-1:0]        re,
  input  logic [RD_PORTS*ADDR_W-1:0] raddr,
  output logic [RD_PORTS*DATA_W-1:0] rdata,
  input  logic [FWD_SRCS-1:0]        fwd_we,
  input  logic [FWD_SRCS*ADDR_W-1:0] fwd_addr,
  input  logic [FWD_SRCS*DATA_W-1:0] fwd_data,
  input  logic [FWD_SRCS-1:0]        fwd_valid,
  output logic                       stall_req
`ifdef REGFILE_STALL_CNT_EN
  ,
  output logic [31:0]                stall_cnt
`endif
);

  localparam int REG_COUNT = 2 ** ADDR_W;

  logic [DATA_W-1:0]   regs_q [REG_COUNT];
  logic [RD_PORTS-1:0] hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else if ((we == WRITE_ENABLE) && (waddr != ADDR_W'(NOP_REG_ADDR))) begin
      regs_q[waddr] <= wdata;
    end
  end

  generate
    for (genvar gi = 0; gi < RD_PORTS; gi++) begin : g_port
      logic [ADDR_W-1:0] port_addr;
      assign port_addr = raddr[gi*ADDR_W +: ADDR_W];

      regfile_fwd_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .FWD_SRCS (FWD_SRCS)
      ) u_port (
        .rst       (rst),
        .re        (re[gi]),
        .raddr     (port_addr),
        .fwd_we    (fwd_we),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .fwd_valid (fwd_valid),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .arr_data  (regs_q[port_addr]),
        .rdata     (rdata[gi*DATA_W +: DATA_W]),
        .hazard    (hazard[gi])
      );
    end
  endgenerate

  // Port hazards are already masked by re and rst inside each resolve unit.
  assign stall_req = |hazard;

`ifdef REGFILE_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_req && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/regfile_fwd.md
# regfile_fwd

Parametrised general-purpose register file for the OpenMIPS pipeline. It has a configurable number of read ports and forwarding sources, and includes load-use hazard detection. It sits between the ID stage and write-back, and absorbs the EX/MEM forwarding muxes that ID currently carries. It resolves every operand read against the youngest in-flight result and raises a stall request when that result is not yet available.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; REG_COUNT = 2**ADDR_W
- RD_PORTS, 2, number of read ports
- FWD_SRCS, 2, number of forwarding sources; index 0 is the youngest (EX), ascending index is older
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- we  in  1  write-back enable
- waddr  in  ADDR_W  write-back address
- wdata  in  DATA_W  write-back data
- re  in  RD_PORTS  per-port read enable
- raddr  in  RD_PORTS*ADDR_W  read addresses, port p at bits [p*ADDR_W +: ADDR_W]
- rdata  out  RD_PORTS*DATA_W  read data, same packing as raddr
- fwd_we  in  FWD_SRCS  source s will write a register
- fwd_addr  in  FWD_SRCS*ADDR_W  destination of source s
- fwd_data  in  FWD_SRCS*DATA_W  result of source s
- fwd_valid  in  FWD_SRCS  result of source s is ready (0 = load still in flight)
- stall_req  out  1  load-use hazard; ID/IF must hold
- stall_cnt  out  32  stall-cycle counter (only with REGFILE_STALL_CNT_EN)

## Operation
- Storage is REG_COUNT x DATA_W. Register 0 reads as 0, and writes to it are discarded.
- Write: on the rising clk edge, if we=1 and waddr!=0, then reg[waddr] <= wdata.
- Read, per port p, combinational, first rule that applies:
  - rst=1 or re[p]=0 or raddr_p=0: rdata_p = 0.
  - Lowest s with fwd_we[s]=1 and fwd_addr_s = raddr_p:
    - fwd_valid[s]=1: rdata_p = fwd_data_s.
    - fwd_valid[s]=0: rdata_p = 0 and a hazard is flagged.
    - Older sources are ignored even if valid.
  - we=1 and waddr = raddr_p: rdata_p = wdata (write-through bypass).
  - Otherwise: rdata_p = reg[raddr_p].
- stall_req is the OR of hazards over all ports with re=1. Sources with fwd_addr=0 never match.
- A forwarding source with fwd_we=0 is ignored regardless of its address, data and valid bit.

## Timing
- All read paths and stall_req are combinational, zero latency. The write has a 1-cycle latency to the array, but the bypass makes it visible in the same cycle.
- Reset (asynchronous assert, synchronous-safe release):
  - All registers are cleared to 0.
  - rdata = 0, stall_req = 0, stall_cnt = 0.
- Reset asserted mid-write: the write is lost and the register reads 0.
- Simultaneous events:
  - WB and EX target the same register: the EX source wins.
  - Multiple ports hitting the same hazard: a single stall_req.
- stall_req carries no handshake state. It deasserts in the cycle the source raises fwd_valid or the hazard moves out of the sources.

## Configuration
- REGFILE_STALL_CNT_EN defined:
  - stall_cnt increments on each rising edge where stall_req=1.
  - It saturates at 32'hFFFF_FFFF, is cleared by rst, and has no other clear.
- REGFILE_STALL_CNT_EN undefined:
  - The stall_cnt port is absent and no counter flops are generated.
  - All other behaviour is identical.

## Structure
- Shared package/define file:
  - DATA_W/ADDR_W defaults (RegBus, RegAddrBus widths).
  - ZeroWord, NOPRegAddr.
  - Read/Write enable constants.
- Sub-module: regfile_fwd_port, the per-port resolve unit.
  - It takes raddr, re, the full forwarding bus, the WB bypass and the array read value.
  - It returns rdata_p and hazard_p, and is instantiated RD_PORTS times by a generate loop.
- The top level holds the array, the write logic, the stall OR-reduce and the optional counter.

## Test plan
- Reset: rst=1 mid-run after writing r5=32'h1234 -> reg[5] reads 0 after release, and rdata=0, stall_req=0 during reset.
- Zero register: write r0=32'hFFFF_FFFF, then read r0 on both ports -> 0. Also fwd_we[0]=1 with fwd_addr=0 -> no forward, no stall.
- Priority chain with r3 in array = 1, WB r3 = 2, src1 r3 = 3, src0 r3 = 4:
  - All valid -> 4.
  - Drop src0 -> 3.
  - Drop src1 -> 2.
  - Drop we -> 1.
- Load-use: src0 r7 with fwd_valid=0, port1 reads r7 -> stall_req=1, rdata1=0. Next cycle the same entry moves to src1 with valid=1 -> stall_req=0, rdata1 = fwd_data_1.
- Masked read: re[0]=0 on a hazard address -> no stall, rdata0=0.
- Counter (macro on): hold stall for 5 cycles -> stall_cnt=5. Preload near saturation via a long stall -> holds at 32'hFFFF_FFFF. With the macro off, the build has no stall_cnt port.
